// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : snoop_bus_arbiter
// Description : Round-robin arbiter and transaction sequencer for the shared
//               three-CPU snooping bus (grant, broadcast, snoop, complete).
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_bus_arbiter #(
    parameter int MSG_W        = 10,
    parameter int SNOOP_CYCLES = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [2:0]       req,
    input  logic [MSG_W-1:0] msg0,
    input  logic [MSG_W-1:0] msg1,
    input  logic [MSG_W-1:0] msg2,
    input  logic [2:0]       snoop_shared,
    output logic [MSG_W-1:0] bus,
    output logic             bus_valid,
    output logic [2:0]       grant,
    output logic [2:0]       listen,
    output logic [2:0]       done,
    output logic             shared,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BCAST = 2'd1,
        ST_SNOOP = 2'd2
    } state_t;

    localparam logic [3:0] c_CNT_INIT = 4'(SNOOP_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [2:0]       r_acc, w_acc_nxt;
    logic [1:0]       r_winner, w_winner_nxt;
    logic [MSG_W-1:0] r_bus, w_bus_nxt;
    logic             r_bus_valid, w_bus_valid_nxt;
    logic [2:0]       r_grant, w_grant_nxt;
    logic [2:0]       r_listen, w_listen_nxt;
    logic [2:0]       r_done, w_done_nxt;
    logic             r_shared, w_shared_nxt;
    logic             r_busy, w_busy_nxt;

    logic [1:0]       w_cand0, w_cand1, w_cand2;
    logic [1:0]       w_rr_win;
    logic [MSG_W-1:0] w_win_msg;
    logic [2:0]       w_snoop_acc;

    function automatic logic [1:0] f_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Search order starts at the pointer, so the last owner is tried last.
    always_comb begin
        w_cand0  = r_ptr;
        w_cand1  = f_next(r_ptr);
        w_cand2  = f_next(w_cand1);
        w_rr_win = w_cand2;
        if (req[w_cand0]) begin
            w_rr_win = w_cand0;
        end else if (req[w_cand1]) begin
            w_rr_win = w_cand1;
        end
    end

    always_comb begin
        case (w_rr_win)
            2'd0:    w_win_msg = msg0;
            2'd1:    w_win_msg = msg1;
            default: w_win_msg = msg2;
        endcase
    end

    // The owner never snoops its own request.
    assign w_snoop_acc = r_acc | (snoop_shared & ~r_grant);

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_acc_nxt       = r_acc;
        w_winner_nxt    = r_winner;
        w_bus_nxt       = r_bus;
        w_bus_valid_nxt = r_bus_valid;
        w_grant_nxt     = r_grant;
        w_listen_nxt    = r_listen;
        w_done_nxt      = r_done;
        w_shared_nxt    = r_shared;
        w_busy_nxt      = r_busy;
        case (r_state)
            ST_IDLE: begin
                w_done_nxt   = 3'b000;
                w_shared_nxt = 1'b0;
                if (|req) begin
                    w_grant_nxt     = 3'b001 << w_rr_win;
                    w_winner_nxt    = w_rr_win;
                    w_bus_nxt       = w_win_msg;
                    w_bus_valid_nxt = 1'b1;
                    w_acc_nxt       = 3'b000;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = ST_BCAST;
                end
            end
            ST_BCAST: begin
                w_bus_valid_nxt = 1'b0;
                w_bus_nxt       = '0;
                w_listen_nxt    = ~r_grant;
                w_cnt_nxt       = c_CNT_INIT;
                w_state_nxt     = ST_SNOOP;
            end
            ST_SNOOP: begin
                w_acc_nxt = w_snoop_acc;
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_done_nxt   = r_grant;
                    w_shared_nxt = |w_snoop_acc;
                    w_grant_nxt  = 3'b000;
                    w_listen_nxt = 3'b000;
                    w_ptr_nxt    = f_next(r_winner);
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_cnt       <= 4'd0;
            r_acc       <= 3'b000;
            r_winner    <= 2'd0;
            r_bus       <= '0;
            r_bus_valid <= 1'b0;
            r_grant     <= 3'b000;
            r_listen    <= 3'b000;
            r_done      <= 3'b000;
            r_shared    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_winner    <= w_winner_nxt;
            r_bus       <= w_bus_nxt;
            r_bus_valid <= w_bus_valid_nxt;
            r_grant     <= w_grant_nxt;
            r_listen    <= w_listen_nxt;
            r_done      <= w_done_nxt;
            r_shared    <= w_shared_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus       = r_bus;
    assign bus_valid = r_bus_valid;
    assign grant     = r_grant;
    assign listen    = r_listen;
    assign done      = r_done;
    assign shared    = r_shared;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_snoop_bus_arbiter
// Description : Self-checking bench for snoop_bus_arbiter against a
//               transaction-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_bus_arbiter;

    localparam int MSG_W = 10;
    localparam int SC    = 2;

    logic             clock = 1'b0;
    logic             clear = 1'b1;
    logic [2:0]       req = 3'b000;
    logic [MSG_W-1:0] msg0 = '0, msg1 = '0, msg2 = '0;
    logic [2:0]       snoop_shared = 3'b000;
    logic [MSG_W-1:0] bus;
    logic             bus_valid;
    logic [2:0]       grant, listen, done;
    logic             shared, busy;

    int total = 0;
    int bad   = 0;

    snoop_bus_arbiter #(.MSG_W(MSG_W), .SNOOP_CYCLES(SC)) dut (
        .clock(clock), .clear(clear), .req(req),
        .msg0(msg0), .msg1(msg1), .msg2(msg2),
        .snoop_shared(snoop_shared),
        .bus(bus), .bus_valid(bus_valid), .grant(grant), .listen(listen),
        .done(done), .shared(shared), .busy(busy)
    );

    always #5 clock = ~clock;

    // Model: a transaction is a timeline of edges t=0 (grant) .. SC+1 (done).
    bit               m_active = 0;
    bit               m_done   = 0;
    int               m_t      = 0;
    int               m_ptr    = 0;
    int               m_win    = 0;
    logic [2:0]       m_acc    = 3'b000;
    logic [MSG_W-1:0] m_msg    = '0;

    function automatic logic [MSG_W-1:0] msg_of(input int i);
        return (i == 0) ? msg0 : (i == 1) ? msg1 : msg2;
    endfunction

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_active = 0; m_done = 0; m_t = 0; m_ptr = 0; m_win = 0;
            m_acc = 3'b000; m_msg = '0;
        end else if (m_active) begin
            m_t = m_t + 1;
            if (m_t >= 2) m_acc = m_acc | (snoop_shared & ~(3'b001 << m_win));
            if (m_t == SC + 1) begin
                m_active = 0;
                m_done   = 1;
                m_ptr    = (m_win + 1) % 3;
            end
        end else begin
            m_done = 0;
            if (req != 3'b000) begin
                for (int off = 2; off >= 0; off--)
                    if (req[(m_ptr + off) % 3]) m_win = (m_ptr + off) % 3;
                m_active = 1;
                m_t      = 0;
                m_acc    = 3'b000;
                m_msg    = msg_of(m_win);
            end
        end
    end

    function automatic logic [21:0] obs_vec();
        return {bus, bus_valid, grant, listen, done, shared, busy};
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [2:0] oh;
        oh = 3'b001 << m_win;
        if (m_active && m_t == 0) return {m_msg, 1'b1, oh, 3'b000, 3'b000, 1'b0, 1'b1};
        if (m_active)             return {10'd0, 1'b0, oh, ~oh, 3'b000, 1'b0, 1'b1};
        if (m_done)               return {10'd0, 1'b0, 3'b000, 3'b000, oh, |m_acc, 1'b0};
        return 22'd0;
    endfunction

    task automatic do_reset();
        clear = 1'b1; req = 3'b000; snoop_shared = 3'b000;
        @(negedge clock); @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        req = 3'b111; msg0 = 10'h111; msg1 = 10'h222; msg2 = 10'h333;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL reset_run cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
        end
        #2 clear = 1'b1;
        #1 total++;
        if (obs_vec() !== 22'd0) begin
            bad++; $display("FAIL reset_async got=%h want=0", obs_vec());
        end
        @(negedge clock);
        clear = 1'b0; req = 3'b000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            total++;
            if (obs_vec() !== 22'd0 || exp_vec() !== 22'd0) begin
                bad++; $display("FAIL reset_quiet cyc=%0d got=%h want=0", c, obs_vec());
            end
        end
    endtask

    task automatic test_single_request(input logic [2:0] snp, input logic exp_sh, input string tag);
        int g_cyc, d_cyc;
        g_cyc = -1; d_cyc = -1;
        do_reset();
        msg0 = 10'($urandom); msg1 = 10'h0C8; msg2 = 10'($urandom);
        req = 3'b010;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL %s_model cyc=%0d got=%h want=%h", tag, c, obs_vec(), exp_vec());
            end
            if (bus_valid && g_cyc < 0) begin
                g_cyc = c;
                total++;
                if (bus !== 10'h0C8 || grant !== 3'b010) begin
                    bad++; $display("FAIL %s_bcast bus=%h grant=%b want bus=0c8 grant=010", tag, bus, grant);
                end
            end
            if (listen !== 3'b000) begin
                total++;
                if (listen !== 3'b101) begin
                    bad++; $display("FAIL %s_listen got=%b want=101", tag, listen);
                end
            end
            if (done !== 3'b000 && d_cyc < 0) begin
                d_cyc = c;
                total++;
                if (done !== 3'b010 || shared !== exp_sh) begin
                    bad++; $display("FAIL %s_done done=%b shared=%b want 010/%b", tag, done, shared, exp_sh);
                end
            end
            snoop_shared = (m_active && m_t >= 1) ? snp : 3'b000;
            if (m_done) req = 3'b000;
        end
        total++;
        if (g_cyc < 0 || d_cyc - g_cyc != SC + 1) begin
            bad++; $display("FAIL %s_latency grant_cyc=%0d done_cyc=%0d want gap %0d", tag, g_cyc, d_cyc, SC + 1);
        end
    endtask

    task automatic test_fairness();
        logic [2:0] seq [4];
        int         cyc [4];
        int         n;
        logic [2:0] want [4];
        want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b001;
        n = 0;
        clear = 1'b1; req = 3'b111;
        @(negedge clock); @(negedge clock);
        clear = 1'b0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clock);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL fair_model cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (bus_valid && n < 4) begin
                seq[n] = grant; cyc[n] = c; n++;
            end
        end
        total++;
        if (n != 4) begin
            bad++; $display("FAIL fair_count got=%0d want=4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (seq[i] !== want[i] || (i > 0 && cyc[i] - cyc[i-1] != SC + 2)) begin
                    bad++; $display("FAIL fair_seq%0d grant=%b gap=%0d want %b gap %0d",
                                    i, seq[i], (i > 0) ? cyc[i] - cyc[i-1] : 0, want[i], SC + 2);
                end
            end
        end
    endtask

    task automatic test_ptr_wrap();
        logic [2:0] seq [3];
        int         n;
        n = 0;
        do_reset();
        req = 3'b010;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL wrap_model cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (bus_valid && n < 3) begin
                seq[n] = grant; n++;
            end
            if (m_done && req == 3'b010) req = 3'b101;
        end
        total++;
        if (n != 3 || seq[0] !== 3'b010 || seq[1] !== 3'b100 || seq[2] !== 3'b001) begin
            bad++; $display("FAIL wrap_seq n=%0d got=%b,%b,%b want 010,100,001", n, seq[0], seq[1], seq[2]);
        end
    endtask

    task automatic test_accum_abort();
        bit         seen, aborted, done2;
        logic [2:0] first_after;
        seen = 0; aborted = 0; done2 = 0; first_after = 3'b000;
        do_reset();
        req = 3'b100;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL accum_model cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (done !== 3'b000 && !seen) begin
                seen = 1;
                total++;
                if (done !== 3'b100 || shared !== 1'b1) begin
                    bad++; $display("FAIL accum_done done=%b shared=%b want 100/1", done, shared);
                end
            end
            snoop_shared = (m_active && m_t == 1) ? 3'b001 : 3'b000;
            if (m_done) req = 3'b000;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL accum_seen got=0 want=1");
        end
        // CPU0 moves the pointer to 1 so the abort must visibly restore it.
        req = 3'b001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL abort_pre cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (m_done) req = 3'b000;
        end
        req = 3'b100;
        for (int c = 0; c < 14; c++) begin
            @(negedge clock);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL abort_model cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            if (done === 3'b100) done2 = 1;
            if (aborted && bus_valid && first_after == 3'b000) first_after = grant;
            if (!aborted && m_active && m_t == 2) begin
                #2 clear = 1'b1;
                @(negedge clock);
                clear = 1'b0; req = 3'b011; aborted = 1;
            end
        end
        total++;
        if (done2) begin
            bad++; $display("FAIL abort_done got=done for aborted owner want=none");
        end
        total++;
        if (!aborted || first_after !== 3'b001) begin
            bad++; $display("FAIL abort_next got=%b want=001", first_after);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL rand_model cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            clear = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) req = 3'($urandom);
            msg0 = 10'($urandom); msg1 = 10'($urandom); msg2 = 10'($urandom);
            snoop_shared = 3'($urandom);
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_request(3'b100, 1'b1, "single");
        test_single_request(3'b010, 1'b0, "mask");
        test_fairness();
        test_ptr_wrap();
        test_accum_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
